// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
package int_arbiter_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StSettle = 2'd2
    } arb_state_e;

    // Source vector numbers presented on int_num.
    localparam logic [1:0] INT1 = 2'd1;
    localparam logic [1:0] INT2 = 2'd2;
    localparam logic [1:0] INT3 = 2'd3;

    // Reset value of {global_en, mask}: everything enabled.
    localparam logic [3:0] MASK_RST = 4'b1111;

endpackage

// File: rtl/int_arbiter_irq_sync.sv
// Multi-stage synchronizer plus history flop producing one-cycle rising-edge pulses.
module int_arbiter_irq_sync #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] irq_raw,
    output logic [WIDTH-1:0] irq_edge
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;

    // Shift raw requests through the synchronizer chain, then into the history flop.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= irq_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, priority masking with nesting,
// and a request/ack handshake to the pipeline with a settle gap after each ack.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int unsigned NSRC        = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [NSRC-1:0]             irq_in,
    input  logic                        mask_we,
    input  logic [NSRC:0]               mask_wdata,
    input  logic                        int_ack,
    input  logic                        eret,
    output logic                        int_req,
    output logic [$clog2(NSRC+1)-1:0]   int_num,
    output logic [NSRC-1:0]             pending,
    output logic [NSRC-1:0]             in_service,
    output logic [NSRC:0]               mask_q
);

    localparam int unsigned NumW = $clog2(NSRC + 1);

    arb_state_e      state_q, state_d;
    logic [NumW-1:0] num_q, num_d;
    logic [NSRC-1:0] pending_d, in_service_d;
    logic [NSRC-1:0] irq_edge;
    logic [NumW-1:0] cur_level;
    logic [NSRC-1:0] eligible;
    logic [NumW-1:0] best_num;
    logic            any_eligible;
    logic [NSRC-1:0] lat_vec;
    logic [NSRC-1:0] hi_vec;
    logic            ack_take;

    int_arbiter_irq_sync #(
        .WIDTH       (NSRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clock    (clock),
        .rst      (rst),
        .irq_raw  (irq_in),
        .irq_edge (irq_edge)
    );

    // Current nesting level and one-hot of the highest in-service source.
    always_comb begin
        cur_level = '0;
        hi_vec    = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (in_service[i]) begin
                cur_level = NumW'(i + 1);
                hi_vec    = '0;
                hi_vec[i] = 1'b1;
            end
        end
    end

    // Eligibility, highest eligible source, and one-hot of the latched source.
    always_comb begin
        best_num     = '0;
        any_eligible = 1'b0;
        eligible     = '0;
        lat_vec      = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            eligible[i] = pending[i] & mask_q[i] & mask_q[NSRC] & (NumW'(i + 1) > cur_level);
            lat_vec[i]  = (num_q == NumW'(i + 1));
            if (eligible[i]) begin
                best_num     = NumW'(i + 1);
                any_eligible = 1'b1;
            end
        end
    end

    // FSM next state, latched vector and pipeline-facing outputs.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        ack_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_eligible) begin
                    state_d = StReq;
                    num_d   = best_num;
                end
            end
            StReq: begin
                if (int_ack) begin
                    state_d  = StSettle;
                    ack_take = 1'b1;
                end else if (~|(eligible & lat_vec)) begin
                    // Latched source withdrawn by a mask write.
                    state_d = StIdle;
                end
            end
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        int_req = (state_q == StReq);
        int_num = int_req ? num_q : '0;
    end

    // Pending and nesting updates; eret clears the old top level before the ack sets its bit.
    always_comb begin
        pending_d    = pending;
        in_service_d = in_service;
        if (ack_take) begin
            pending_d = pending & ~lat_vec;
        end
        // A new edge on the acked source in the same cycle keeps it pending.
        pending_d = pending_d | irq_edge;
        if (eret) begin
            in_service_d = in_service_d & ~hi_vec;
        end
        if (ack_take) begin
            in_service_d = in_service_d | lat_vec;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= StIdle;
            num_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            mask_q     <= MASK_RST;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            pending    <= pending_d;
            in_service <= in_service_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Table-driven cycle-by-cycle check of the interrupt arbiter plus a bounded latency sequence.
module tb_int_arbiter;
    import int_arbiter_pkg::*;

    logic       clock;
    logic       rst;
    logic [2:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_ack;
    logic       eret;
    logic       int_req;
    logic [1:0] int_num;
    logic [2:0] pending;
    logic [2:0] in_service;
    logic [3:0] mask_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] irq;
        logic       we;
        logic [3:0] wd;
        logic       ack;
        logic       er;
        logic       req;
        logic [1:0] num;
        logic [2:0] pend;
        logic [2:0] insv;
        logic [3:0] mask;
    } row_t;

    row_t rows[$];

    localparam logic [3:0] M = 4'b1111;

    int_arbiter #(
        .NSRC        (3),
        .SYNC_STAGES (2)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_num    (int_num),
        .pending    (pending),
        .in_service (in_service),
        .mask_q     (mask_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input string nm, input logic r, input logic [2:0] irq, input logic we,
                       input logic [3:0] wd, input logic ack, input logic er, input logic req,
                       input logic [1:0] num, input logic [2:0] pd, input logic [2:0] is,
                       input logic [3:0] mk);
        row_t t;
        t.name = nm; t.rst = r; t.irq = irq; t.we = we; t.wd = wd; t.ack = ack; t.er = er;
        t.req = req; t.num = num; t.pend = pd; t.insv = is; t.mask = mk;
        rows.push_back(t);
    endtask

    // Plain step: no rst, no mask write.
    task automatic st(input string nm, input logic [2:0] irq, input logic ack, input logic er,
                      input logic req, input logic [1:0] num, input logic [2:0] pd,
                      input logic [2:0] is);
        add(nm, 1'b0, irq, 1'b0, 4'b0, ack, er, req, num, pd, is, M);
    endtask

    task automatic check_row(input row_t t);
        checks++;
        if ({int_req, int_num, pending, in_service, mask_q} !==
            {t.req, t.num, t.pend, t.insv, t.mask}) begin
            failures++;
            $display("FAIL %s: got req=%b num=%0d pend=%b insv=%b mask=%b, want req=%b num=%0d pend=%b insv=%b mask=%b",
                     t.name, int_req, int_num, pending, in_service, mask_q,
                     t.req, t.num, t.pend, t.insv, t.mask);
        end
    endtask

    task automatic check1(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        int req_edge;
        int pend_edge;
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eret = 1'b0;

        // Reset state.
        add("reset", 1'b1, 3'b000, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, M);

        // Single INT_2 pulse, no ack: request holds.
        st("a_e1",  3'b010, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("a_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("a_e3",  3'b000, 0, 0, 0, 2'd0, 3'b010, 3'b000);
        st("a_e4",  3'b000, 0, 0, 1, INT2, 3'b010, 3'b000);
        for (int i = 0; i < 10; i++) st("a_hold", 3'b000, 0, 0, 1, INT2, 3'b010, 3'b000);
        st("a_ack", 3'b000, 1, 0, 0, 2'd0, 3'b000, 3'b010);
        st("a_eret", 3'b000, 0, 1, 0, 2'd0, 3'b000, 3'b000);

        // INT_1 and INT_3 together: INT_3 first, INT_1 blocked until eret.
        st("b_e1",  3'b101, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("b_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("b_e3",  3'b000, 0, 0, 0, 2'd0, 3'b101, 3'b000);
        st("b_req3", 3'b000, 0, 0, 1, INT3, 3'b101, 3'b000);
        st("b_ack3", 3'b000, 1, 0, 0, 2'd0, 3'b001, 3'b100);
        st("b_settle", 3'b000, 0, 0, 0, 2'd0, 3'b001, 3'b100);
        st("b_blocked", 3'b000, 0, 0, 0, 2'd0, 3'b001, 3'b100);
        st("b_eret", 3'b000, 0, 1, 0, 2'd0, 3'b001, 3'b000);
        st("b_req1", 3'b000, 0, 0, 1, INT1, 3'b001, 3'b000);
        st("b_ack1", 3'b000, 1, 0, 0, 2'd0, 3'b000, 3'b001);
        st("b_idle", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b001);

        // Nesting: INT_3 preempts in-service INT_1.
        st("c_e1",  3'b100, 0, 0, 0, 2'd0, 3'b000, 3'b001);
        st("c_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b001);
        st("c_e3",  3'b000, 0, 0, 0, 2'd0, 3'b100, 3'b001);
        st("c_req3", 3'b000, 0, 0, 1, INT3, 3'b100, 3'b001);
        st("c_ack3", 3'b000, 1, 0, 0, 2'd0, 3'b000, 3'b101);
        st("c_eret1", 3'b000, 0, 1, 0, 2'd0, 3'b000, 3'b001);
        st("c_eret2", 3'b000, 0, 1, 0, 2'd0, 3'b000, 3'b000);

        // eret and ack in the same cycle.
        st("d_e1",  3'b001, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("d_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("d_e3",  3'b000, 0, 0, 0, 2'd0, 3'b001, 3'b000);
        st("d_req1", 3'b000, 0, 0, 1, INT1, 3'b001, 3'b000);
        st("d_ack1", 3'b000, 1, 0, 0, 2'd0, 3'b000, 3'b001);
        st("d_idle", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b001);
        st("d_f1",  3'b010, 0, 0, 0, 2'd0, 3'b000, 3'b001);
        st("d_f2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b001);
        st("d_f3",  3'b000, 0, 0, 0, 2'd0, 3'b010, 3'b001);
        st("d_req2", 3'b000, 0, 0, 1, INT2, 3'b010, 3'b001);
        st("d_ack_eret", 3'b000, 1, 1, 0, 2'd0, 3'b000, 3'b010);
        st("d_eret", 3'b000, 0, 1, 0, 2'd0, 3'b000, 3'b000);

        // Mask withdrawal, ignored ack, reissue, and edge coinciding with ack.
        st("m_e1",  3'b010, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("m_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("m_e3",  3'b000, 0, 0, 0, 2'd0, 3'b010, 3'b000);
        st("m_req2", 3'b000, 0, 0, 1, INT2, 3'b010, 3'b000);
        add("m_wr", 1'b0, 3'b000, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, INT2, 3'b010, 3'b000, 4'b1101);
        add("m_drop", 1'b0, 3'b000, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b010, 3'b000, 4'b1101);
        add("m_ack_ign", 1'b0, 3'b000, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'b010, 3'b000,
            4'b1101);
        add("m_wr2", 1'b0, 3'b010, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 3'b010, 3'b000, M);
        st("m_reissue", 3'b000, 0, 0, 1, INT2, 3'b010, 3'b000);
        st("m_ack_edge", 3'b000, 1, 0, 0, 2'd0, 3'b010, 3'b010);
        st("m_eret", 3'b000, 0, 1, 0, 2'd0, 3'b010, 3'b000);
        st("m_req2b", 3'b000, 0, 0, 1, INT2, 3'b010, 3'b000);
        st("m_ack2", 3'b000, 1, 0, 0, 2'd0, 3'b000, 3'b010);
        st("m_eret2", 3'b000, 0, 1, 0, 2'd0, 3'b000, 3'b000);

        // Reset in the middle of a request.
        st("r_e1",  3'b001, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("r_e2",  3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("r_e3",  3'b000, 0, 0, 0, 2'd0, 3'b001, 3'b000);
        st("r_req1", 3'b000, 0, 0, 1, INT1, 3'b001, 3'b000);
        add("r_wr", 1'b0, 3'b000, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, INT1, 3'b001, 3'b000, 4'b1011);
        add("r_rst", 1'b1, 3'b000, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, M);
        st("r_quiet1", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("r_quiet2", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);

        // irq held high through reset release: exactly one edge.
        add("h_rst1", 1'b1, 3'b100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, M);
        add("h_rst2", 1'b1, 3'b100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, M);
        st("h_e1",  3'b100, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("h_e2",  3'b100, 0, 0, 0, 2'd0, 3'b000, 3'b000);
        st("h_e3",  3'b100, 0, 0, 0, 2'd0, 3'b100, 3'b000);
        st("h_req3", 3'b100, 0, 0, 1, INT3, 3'b100, 3'b000);
        st("h_hold1", 3'b100, 0, 0, 1, INT3, 3'b100, 3'b000);
        st("h_hold2", 3'b100, 0, 0, 1, INT3, 3'b100, 3'b000);
        st("h_ack3", 3'b100, 1, 0, 0, 2'd0, 3'b000, 3'b100);
        st("h_once1", 3'b100, 0, 0, 0, 2'd0, 3'b000, 3'b100);
        st("h_once2", 3'b100, 0, 0, 0, 2'd0, 3'b000, 3'b100);
        st("h_eret", 3'b100, 0, 1, 0, 2'd0, 3'b000, 3'b000);
        st("h_low", 3'b000, 0, 0, 0, 2'd0, 3'b000, 3'b000);

        foreach (rows[k]) begin
            @(negedge clock);
            rst = rows[k].rst; irq_in = rows[k].irq; mask_we = rows[k].we;
            mask_wdata = rows[k].wd; int_ack = rows[k].ack; eret = rows[k].er;
            @(posedge clock);
            #1;
            check_row(rows[k]);
        end

        // Latency: irq_in high before edge 1 -> pending after edge 3 -> int_req after edge 4.
        @(negedge clock);
        rst = 1'b0; irq_in = 3'b001; mask_we = 1'b0; int_ack = 1'b0; eret = 1'b0;
        req_edge  = 0;
        pend_edge = 0;
        for (int n = 1; n <= 20 && req_edge == 0; n++) begin
            @(posedge clock);
            #1;
            if (pend_edge == 0 && pending[0]) pend_edge = n;
            if (int_req) req_edge = n;
        end
        check1("lat_pending_edge", 8'(pend_edge), 8'd3);
        check1("lat_req_edge", 8'(req_edge), 8'd4);
        check1("lat_num", {6'd0, int_num}, {6'd0, INT1});
        @(negedge clock);
        irq_in = 3'b000; int_ack = 1'b1;
        @(posedge clock);
        #1;
        check1("lat_ack_insv", {5'd0, in_service}, 8'd1);
        @(negedge clock);
        int_ack = 1'b0; eret = 1'b1;
        @(posedge clock);
        #1;
        check1("lat_eret_insv", {5'd0, in_service}, 8'd0);
        eret = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NSRC, default 3, number of interrupt sources (the ports below fix NSRC=3).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth.
REQ-003 clock  input  1  rising-edge clock, same net as the pipeline stage registers.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  3  raw asynchronous requests; bit0=INT_1, bit1=INT_2, bit2=INT_3.
REQ-006 mask_we  input  1  write strobe for the mask register (mtc0 to IE, EX stage).
REQ-007 mask_wdata  input  4  new {global_en, mask[2:0]}.
REQ-008 int_ack  input  1  pipeline has taken the interrupt (EX int_tri) this cycle.
REQ-009 eret  input  1  return-from-interrupt executing in EX this cycle.
REQ-010 int_req  output  1  interrupt request to the pipeline.
REQ-011 int_num  output  2  vector of the requested source (1..3); 0 when int_req=0.
REQ-012 pending  output  3  latched, not-yet-serviced requests.
REQ-013 in_service  output  3  sources currently being serviced (nesting state).
REQ-014 mask_q  output  4  current {global_en, mask}.

Function
REQ-015 Each irq_in bit SHALL pass SYNC_STAGES flops plus one history flop; edge = sync_out & ~history.
REQ-016 A rising edge SHALL set its pending bit; repeated edges while set SHALL NOT be counted.
REQ-017 Priority: INT_3 > INT_2 > INT_1; cur_level = index+1 of the highest in_service bit, 0 if none.
REQ-018 Source s is eligible iff pending[s] & mask[s] & global_en & (s+1 > cur_level).
REQ-019 FSM states: IDLE, REQ, SETTLE.
REQ-020 IDLE -> REQ when any source is eligible; latch the highest eligible source into int_num.
REQ-021 In REQ: int_req=1 and int_num SHALL stay stable until int_ack or withdrawal.
REQ-022 REQ + int_ack -> SETTLE: set in_service[latched], clear pending[latched].
REQ-023 REQ with the latched source no longer eligible (mask write) and no int_ack -> IDLE, int_req drops next cycle.
REQ-024 SETTLE -> IDLE unconditionally; int_req=0 in SETTLE (one-cycle gap for pipeline flush).
REQ-025 eret SHALL clear the highest in_service bit in any state; eret with in_service=0 SHALL be ignored.
REQ-026 Same cycle eret + int_ack: clear highest old in_service bit first, then set the acked bit.
REQ-027 Same cycle edge + ack on the same source: pending SHALL remain 1.
REQ-028 mask_we SHALL update mask_q at the clock edge; eligibility SHALL use the new value from the next cycle.
REQ-029 int_ack outside REQ SHALL be ignored.
REQ-030 Latency: irq_in high before edge 1 -> pending=1 after edge 3 -> int_req=1 after edge 4 (SYNC_STAGES=2, IDLE, eligible).

Reset
REQ-031 rst SHALL force state=IDLE, pending=0, in_service=0, sync and history flops=0, int_req=0, int_num=0, mask_q=4'b1111.
REQ-032 rst mid-request SHALL drop int_req the next cycle with no in_service update.
REQ-033 irq_in held high through rst release SHALL produce exactly one edge after release.

Structure
REQ-034 Shared package: state encoding, source vector constants (INT1=1, INT2=2, INT3=3), MASK_RST=4'b1111.
REQ-035 One sub-module irq_sync (synchronizer + edge detect, width-parameterized), instantiated once for the 3-bit vector.

Verification
REQ-036 Pulse INT_2 only, no ack -> int_req=1, int_num=2 after edge 4; stays high for 10 cycles; pending=3'b010.
REQ-037 INT_1 and INT_3 edges same cycle, ack each -> int_num=3 first; after SETTLE, int_num=1 blocked (in_service=3'b100) until eret; then int_num=1.
REQ-038 Nesting: ack INT_1 (in_service=001), then INT_3 edge -> int_req, int_num=3; ack -> in_service=101; eret -> 001; eret -> 000.
REQ-039 In REQ for INT_2, write mask_wdata=4'b1101 -> int_req=0 next cycle, pending[1] stays 1; write 4'b1111 -> request reissued, int_num=2.
REQ-040 eret and int_ack same cycle with in_service=001, latched INT_2 -> in_service=010.
REQ-041 Assert rst while int_req=1 -> all outputs zero next cycle, mask_q=4'b1111, no spurious request with irq_in=0.
